// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: multi-channel edge-to-pulse generator.
// Each channel synchronises an asynchronous level input, optionally debounces
// it, detects rising/falling/both edges per a 2-bit mode, and stretches each
// qualifying event into a PULSE_LEN-cycle output pulse.
// Optional debounce is compiled in with the macro PULSEGEN_DEBOUNCE_EN; without
// it the filtered level follows the synchroniser output directly.
module pulse_gen_multi #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int PULSE_LEN   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic [2*WIDTH-1:0]   mode,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     level
);

    localparam int ST_W = $clog2(PULSE_LEN + 1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s;
            logic                   lvl_reg;
            logic                   lvl_next;
            logic                   rise;
            logic                   fall;
            logic                   event_hit;
            logic [ST_W-1:0]        st_reg;
            logic [ST_W-1:0]        st_next;

            // Synchroniser shift register; the last stage is the safe sample.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], in[gi]};
                end
            end

            assign s = sync_reg[SYNC_STAGES-1];

`ifdef PULSEGEN_DEBOUNCE_EN
            localparam int CNT_W = $clog2(DB_CYCLES) + 1;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            // Debounce: the level only moves after DB_CYCLES consecutive
            // cycles of disagreement; any agreement restarts the count.
            always_comb begin
                cnt_next = cnt_reg;
                lvl_next = lvl_reg;
                if (s == lvl_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
                    lvl_next = s;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            // Debounce counter register; reset discards pending counts.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
`else
            assign lvl_next = s;
`endif

            // Edges are judged on the level transition happening this edge,
            // so the pulse starts on the same edge the level changes.
            assign rise      = lvl_next & ~lvl_reg;
            assign fall      = ~lvl_next & lvl_reg;
            assign event_hit = (rise & mode[2*gi]) | (fall & mode[2*gi+1]);

            // Stretcher: an event (re)loads the full length, else count down.
            always_comb begin
                st_next = st_reg;
                if (event_hit) begin
                    st_next = ST_W'(PULSE_LEN);
                end else if (st_reg != '0) begin
                    st_next = st_reg - ST_W'(1);
                end
            end

            // Filtered level and stretcher state registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    lvl_reg <= 1'b0;
                    st_reg  <= '0;
                end else begin
                    lvl_reg <= lvl_next;
                    st_reg  <= st_next;
                end
            end

            assign q[gi]     = (st_reg != '0);
            assign level[gi] = lvl_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Testbench for pulse_gen_multi: per-cycle scoreboard against a reference
// model, a table of stimulus segments with hand-derived end-of-segment
// expectations, and hand-written sequences for reset, latency and retrigger.
module tb_pulse_gen_multi;

    localparam int W   = 4;
    localparam int SS  = 2;
    localparam int DB  = 4;
    localparam int PL  = 3;
`ifdef PULSEGEN_DEBOUNCE_EN
    localparam bit DEB    = 1'b1;
    localparam int DB_EFF = DB;
`else
    localparam bit DEB    = 1'b0;
    localparam int DB_EFF = 1;
`endif
    localparam int LAT = SS + DB_EFF;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in    = '0;
    logic [7:0]   mode  = 8'h55;
    logic [W-1:0] q;
    logic [W-1:0] level;

    always #5 clk = ~clk;

    pulse_gen_multi #(
        .WIDTH(W), .SYNC_STAGES(SS), .DB_CYCLES(DB), .PULSE_LEN(PL)
    ) dut (
        .clk(clk), .reset(reset), .in(in), .mode(mode), .q(q), .level(level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [SS-1:0] m_sync [W];
    logic          m_lvl  [W];
    int            m_cnt  [W];
    int            m_st   [W];

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] lvl;
    } exp_t;
    exp_t sb[$];

    logic [W-1:0] q_prev = '0;
    int           rises [W];

    typedef struct {
        logic [W-1:0] in;
        logic [7:0]   mode;
        int           cycles;
        logic [W-1:0] exp_level;
        logic [15:0]  exp_rises;   // nibble per channel, ch0 in [3:0]
    } vec_t;
    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic model_step();
        exp_t e;
        for (int c = 0; c < W; c++) begin
            logic s, nl, ev;
            if (reset) begin
                m_sync[c] = '0;
                m_lvl[c]  = 1'b0;
                m_cnt[c]  = 0;
                m_st[c]   = 0;
            end else begin
                s = m_sync[c][SS-1];
                m_sync[c] = {m_sync[c][SS-2:0], in[c]};
                nl = m_lvl[c];
                if (DEB) begin
                    if (s == m_lvl[c]) m_cnt[c] = 0;
                    else if (m_cnt[c] == DB - 1) begin
                        nl = s;
                        m_cnt[c] = 0;
                    end else m_cnt[c]++;
                end else begin
                    nl = s;
                end
                ev = (nl & ~m_lvl[c] & mode[2*c]) | (~nl & m_lvl[c] & mode[2*c+1]);
                if (ev) m_st[c] = PL;
                else if (m_st[c] != 0) m_st[c]--;
                m_lvl[c] = nl;
            end
            e.q[c]   = (m_st[c] != 0);
            e.lvl[c] = m_lvl[c];
        end
        sb.push_back(e);
    endtask

    // One clock: predict, advance, then compare the DUT after the edge.
    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("q", q, e.q);
        check("level", level, e.lvl);
        for (int c = 0; c < W; c++) begin
            if (q[c] && !q_prev[c]) rises[c]++;
        end
        q_prev = q;
    endtask

    initial begin
        int edge_no;
        int width;
        int run;
        int max_run;
        int noisy;
        bit seen;

        for (int c = 0; c < W; c++) begin
            m_sync[c] = '0; m_lvl[c] = 1'b0; m_cnt[c] = 0; m_st[c] = 0; rises[c] = 0;
        end

        tbl[0]  = '{4'h0, 8'h55, 12, 4'h0, 16'h0000};
        tbl[1]  = '{4'h1, 8'h55, 12, 4'h1, 16'h0001};
        tbl[2]  = '{4'h0, 8'h55, 12, 4'h0, 16'h0000};
        tbl[3]  = '{4'h2, 8'h5D, 12, 4'h2, 16'h0010};
        tbl[4]  = '{4'h0, 8'h5D, 12, 4'h0, 16'h0010};
        tbl[5]  = '{4'hF, 8'h00, 12, 4'hF, 16'h0000};
        tbl[6]  = '{4'h0, 8'hAA, 12, 4'h0, 16'h1111};
`ifdef PULSEGEN_DEBOUNCE_EN
        tbl[7]  = '{4'h4, 8'h55, 3,  4'h0, 16'h0000};
        tbl[8]  = '{4'h0, 8'h55, 12, 4'h0, 16'h0000};
        tbl[9]  = '{4'h4, 8'h55, 4,  4'h0, 16'h0000};
        tbl[10] = '{4'h0, 8'h55, 12, 4'h0, 16'h0100};
`else
        tbl[7]  = '{4'h4, 8'h55, 3,  4'h4, 16'h0100};
        tbl[8]  = '{4'h0, 8'h55, 12, 4'h0, 16'h0000};
        tbl[9]  = '{4'h4, 8'h55, 4,  4'h4, 16'h0100};
        tbl[10] = '{4'h0, 8'h55, 12, 4'h0, 16'h0000};
`endif

        // Reset held 3 cycles with in[0] high: outputs stay 0.
        reset = 1'b1; in = 4'h1; mode = 8'h55;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("reset_q", q, 0);
            check("reset_level", level, 0);
            $display("reset cycle %0d: q=%b level=%b", i, q, level);
        end

        // Release: q[0] must rise exactly LAT edges later, for PL cycles.
        reset = 1'b0;
        edge_no = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            cycle();
            if (q[0]) begin
                seen = 1'b1;
                edge_no = i;
            end
        end
        check("post_reset_latency", edge_no, LAT);
        width = 0;
        for (int i = 0; i < 20 && q[0]; i++) begin
            width++;
            cycle();
        end
        check("post_reset_width", width, PL);
        $display("post-reset: q[0] rose at edge %0d, width %0d", edge_no, width);
        repeat (4) cycle();

        // Table-driven segments
        for (int t = 0; t < 11; t++) begin
            in = tbl[t].in;
            mode = tbl[t].mode;
            for (int c = 0; c < W; c++) rises[c] = 0;
            for (int k = 0; k < tbl[t].cycles; k++) cycle();
            check($sformatf("seg%0d_level", t), level, tbl[t].exp_level);
            for (int c = 0; c < W; c++)
                check($sformatf("seg%0d_rises_ch%0d", t, c), rises[c], tbl[t].exp_rises[4*c +: 4]);
            $display("seg %0d: in=%h mode=%h level=%b rises=%0d/%0d/%0d/%0d",
                     t, tbl[t].in, tbl[t].mode, level, rises[0], rises[1], rises[2], rises[3]);
        end

        // Retrigger: toggle in[3] every 3 cycles with mode 11 on ch3.
        mode = 8'hD5;
        in = 4'h0;
        run = 0; max_run = 0; noisy = 0;
        for (int k = 0; k < 4; k++) begin
            in[3] = ~in[3];
            for (int j = 0; j < 3; j++) begin
                cycle();
                if (q[3]) run++; else run = 0;
                if (run > max_run) max_run = run;
                if (q[2:0] != 3'b000) noisy++;
            end
        end
        for (int j = 0; j < 12; j++) begin
            cycle();
            if (q[3]) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (q[2:0] != 3'b000) noisy++;
        end
        check("retrigger_run", max_run, DEB ? 0 : 3 * 3 + PL);
        check("others_quiet", noisy, 0);
        $display("retrigger: longest q[3] run %0d, other-channel activity %0d", max_run, noisy);

        // Reset mid-pulse truncates the pulse on that edge.
        mode = 8'h55;
        in = 4'h1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (q[0]) seen = 1'b1;
        end
        check("midpulse_seen", seen, 1);
        reset = 1'b1;
        cycle();
        check("midpulse_reset_q", q, 0);
        check("midpulse_reset_level", level, 0);
        $display("mid-pulse reset: q=%b level=%b", q, level);
        reset = 1'b0;
        repeat (12) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pulse_gen_multi.md
# pulse_gen_multi

Multi-channel, parametrised successor to the single-bit edge pulse generator. Each channel synchronises an asynchronous level input and optionally debounces it. It detects rising, falling or both edges according to a per-channel mode, and emits an output pulse of programmable length. It sits between raw board inputs (buttons, switches, external strobes) and the synchronous control logic that consumes single-event pulses.

## Interface
- WIDTH, 4: number of independent channels (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- DB_CYCLES, 4: consecutive stable cycles required before the filtered level changes (>=1; used only when debounce is compiled in).
- PULSE_LEN, 1: output pulse length in clk cycles (>=1).

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- in  in  WIDTH  asynchronous level inputs, one per channel.
- mode  in  2*WIDTH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- q  out  WIDTH  per-channel pulse outputs.
- level  out  WIDTH  per-channel filtered level (the value edges are detected on).

## Operation
Each channel is independent and contains the following stages.
- Synchroniser: SYNC_STAGES-deep shift register; s = last stage.
- Level filter, with debounce:
  - Counter cnt, width clog2(DB_CYCLES)+1.
  - If s == lvl: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: lvl <= s and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DB_CYCLES synchronised cycles never changes lvl.
- Level filter, without debounce: lvl <= s every cycle.
- Edge qualify:
  - rise = lvl updating 0->1 this edge; fall = lvl updating 1->0 this edge.
  - The event qualifies if (rise & mode[2i]) | (fall & mode[2i+1]).
  - mode is sampled on the same edge as the lvl update.
- Stretcher:
  - Counter st, width clog2(PULSE_LEN+1).
  - A qualifying event loads st <= PULSE_LEN; otherwise, if st != 0, st <= st-1.
  - q[i] = (st != 0), driven from registered state only (no combinational path from in or mode).
- Retrigger: a qualifying event while st != 0 reloads PULSE_LEN, so q stays high continuously with no gap.
- Mode change mid-pulse: the current pulse finishes unaffected. Mode 00 suppresses new pulses only; lvl keeps tracking.
- level[i] = lvl.

## Timing
- Reset (synchronous): all sync flops, lvl, cnt and st clear to 0. q = 0 and level = 0 on the first edge with reset high, and they stay 0 while reset is high.
- Reset mid-operation: an in-progress pulse is truncated, and pending debounce counts are discarded.
- After reset deasserts with in held high, lvl sees a 0->1 transition. A channel in rising or both mode therefore emits one pulse. This is required behaviour.
- Latency from in changing before edge 0 to q rising:
  - With debounce: SYNC_STAGES+DB_CYCLES edges (default 6).
  - Without debounce: SYNC_STAGES+1 edges (default 3).
- level changes on the same edge that q rises.
- Pulse width: exactly PULSE_LEN cycles per isolated event.
- Minimum spacing for two distinct pulses: PULSE_LEN+1 cycles between qualifying events. Closer events merge by retrigger.
- Input toggling faster than DB_CYCLES with debounce produces no level change and no pulse.

## Configuration
- Macro PULSEGEN_DEBOUNCE_EN.
  - Defined: the per-channel debounce counter is instantiated, behaving as in Operation; DB_CYCLES is honoured.
  - Undefined: no counter is generated, lvl follows s directly, and DB_CYCLES is ignored. Timing is identical to the defined case with DB_CYCLES = 1.

## Test plan
- Reset behaviour: WIDTH=4, in=0, mode=all 01, debounce on. Assert reset 3 cycles with in[0] high. Required: q=0 and level=0 throughout reset. After release, q[0] rises exactly 6 edges later for 1 cycle.
- Rising edge latency and width: mode[1:0]=01, PULSE_LEN=3, debounce on. in[0] goes 0->1. Required: q[0] high for exactly 3 cycles starting edge 6. A later 1->0 transition produces no pulse.
- Both-edge mode: mode[3:2]=11. Raise in[1] and drop it 20 cycles later. Required: two 1-cycle pulses 20 cycles apart. Also check mode 00 gives none while level still follows.
- Debounce rejection: DB_CYCLES=4. Pulse in[2] high for 3 cycles, then low. Required: level[2] and q[2] stay 0. Hold high 4 cycles: level[2] rises and q[2] pulses.
- Retrigger and independence: PULSE_LEN=4, mode=11. Toggle in[3] every 3 synchronised cycles with debounce off. Required: q[3] high continuously until 4 cycles after the last event. Other channels stay quiet. Also assert reset mid-pulse and check q clears on that edge.
- Without PULSEGEN_DEBOUNCE_EN: rising event on in[0]. Required: q[0] rises at edge 3. A 1-cycle glitch produces a pulse.
